// File: rtl/ray_batch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ray_batch_scheduler
//  Purpose  : Shares one triangle-batch intersection engine among NREQ ray
//             requesters. A round-robin arbiter picks a requester, its ray
//             and triangle count are latched, one batch is launched on the
//             engine, and the engine result is returned with the requester
//             ID. A watchdog aborts a batch whose engine never finishes.
//  Ports    : clk, reset (async, active-high)
//             req_valid/req_ready/req_ray/req_tri_cnt - requester side
//             baseaddr                                - triangle table base
//             eng_start/eng_baseaddr/eng_ray/eng_tri_cnt/eng_reset,
//             eng_hit/eng_t/eng_tri_index/eng_finish  - engine side
//             rsp_valid/rsp_ready/rsp_id/rsp_hit/rsp_t/
//             rsp_tri_index/rsp_err                   - response side
//  Revision : 1.0 - initial release
// ============================================================================
module ray_batch_scheduler #(
    parameter int          NREQ    = 4,
    parameter logic [31:0] TIMEOUT = 32'd1048576,
    parameter int          IDW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [192*NREQ-1:0]    req_ray,
    input  logic [32*NREQ-1:0]     req_tri_cnt,
    input  logic [31:0]            baseaddr,
    output logic                   eng_start,
    output logic [31:0]            eng_baseaddr,
    output logic [191:0]           eng_ray,
    output logic [31:0]            eng_tri_cnt,
    output logic                   eng_reset,
    input  logic                   eng_hit,
    input  logic [31:0]            eng_t,
    input  logic [31:0]            eng_tri_index,
    input  logic                   eng_finish,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_hit,
    output logic [31:0]            rsp_t,
    output logic [31:0]            rsp_tri_index,
    output logic                   rsp_err
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_LAUNCH = 2'd1;
    localparam logic [1:0]  S_WAIT   = 2'd2;
    localparam logic [1:0]  S_RESP   = 2'd3;
    localparam logic [31:0] T_NONE   = 32'h7fffffff;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] id_q;
    logic [191:0]   eng_ray_q;
    logic [31:0]    eng_tri_cnt_q;
    logic [31:0]    eng_baseaddr_q;
    logic [31:0]    wdog_q;
    logic           rsp_hit_q;
    logic [31:0]    rsp_t_q;
    logic [31:0]    rsp_idx_q;
    logic           rsp_err_q;

    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   scan;
    logic [191:0]   lane_ray;
    logic [31:0]    lane_cnt;
    logic           finish_take;
    logic           timeout_hit;
    logic [IDW-1:0] rr_next;

    // Round-robin scan. Offsets are visited from the far end back to rr_ptr
    // so the last hit written is the one closest to rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan        = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (req_valid[scan[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = scan[IDW-1:0];
            end
        end
    end

    assign lane_ray = req_ray[192*int'(grant_id) +: 192];
    assign lane_cnt = req_tri_cnt[32*int'(grant_id) +: 32];

    // Watchdog is zero only in the first WAIT cycle (it saturates rather
    // than wrapping), so it doubles as the "ignore stale finish" marker.
    assign finish_take = (state_q == S_WAIT) && eng_finish && (wdog_q != 32'd0);
    assign timeout_hit = (state_q == S_WAIT) && (TIMEOUT != 32'd0) &&
                         (wdog_q == TIMEOUT - 32'd1) && !finish_take;

    assign rr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d = (lane_cnt == 32'd0) ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (finish_take || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // req_ready is also masked by reset so every output reads zero while
    // reset is held, even with requests pending.
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && grant_valid && !reset) begin
            req_ready[grant_id] = 1'b1;
        end
        eng_start = (state_q == S_LAUNCH);
        rsp_valid = (state_q == S_RESP);
        eng_reset = timeout_hit;
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            id_q           <= '0;
            eng_ray_q      <= '0;
            eng_tri_cnt_q  <= '0;
            eng_baseaddr_q <= '0;
            wdog_q         <= '0;
            rsp_hit_q      <= 1'b0;
            rsp_t_q        <= '0;
            rsp_idx_q      <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            eng_baseaddr_q <= baseaddr;
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        id_q <= grant_id;
                        if (lane_cnt == 32'd0) begin
                            // Empty batch: answer immediately, engine
                            // outputs keep the previous launch's values.
                            rsp_hit_q <= 1'b0;
                            rsp_t_q   <= T_NONE;
                            rsp_idx_q <= '0;
                            rsp_err_q <= 1'b0;
                        end else begin
                            eng_ray_q     <= lane_ray;
                            eng_tri_cnt_q <= lane_cnt;
                        end
                    end
                end
                S_LAUNCH: wdog_q <= '0;
                S_WAIT: begin
                    if (wdog_q != 32'hffffffff) begin
                        wdog_q <= wdog_q + 32'd1;
                    end
                    if (finish_take) begin
                        rsp_hit_q <= eng_hit;
                        rsp_t_q   <= eng_t;
                        rsp_idx_q <= eng_tri_index;
                        rsp_err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_hit_q <= 1'b0;
                        rsp_t_q   <= T_NONE;
                        rsp_idx_q <= '0;
                        rsp_err_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_baseaddr  = eng_baseaddr_q;
    assign eng_ray       = eng_ray_q;
    assign eng_tri_cnt   = eng_tri_cnt_q;
    assign rsp_id        = id_q;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_t         = rsp_t_q;
    assign rsp_tri_index = rsp_idx_q;
    assign rsp_err       = rsp_err_q;

endmodule
`default_nettype wire
